df_mac: RTL

//  Multiply-accumulate stage directly downstream of the dataflow address counter.

---
 rtl/df_mac_if.sv | 28 ++
 rtl/df_mac.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/df_mac_if.sv
// Stream interface between the address counter / RAM side and the df_mac stage.
// The master drives term addresses, RAM data and bias; the slave returns results.
interface df_mac_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int ACC_W  = 20
);
    logic [ADDR_W-1:0]        sel;
    logic                     sel_rdy;
    logic signed [DATA_W-1:0] x_data;
    logic signed [DATA_W-1:0] w_data;
    logic signed [ACC_W-1:0]  bias;
    logic signed [ACC_W-1:0]  sum;
    logic                     sum_rdy;
    logic                     ovf;
    logic                     abort;
    logic                     busy;

    modport master (
        output sel, sel_rdy, x_data, w_data, bias,
        input  sum, sum_rdy, ovf, abort, busy
    );

    modport slave (
        input  sel, sel_rdy, x_data, w_data, bias,
        output sum, sum_rdy, ovf, abort, busy
    );
endinterface

// File: rtl/df_mac.sv
// Three-stage multiply-accumulate: address/valid align, product register, then a
// saturating accumulator FSM that emits one bias-added dot product per N-term vector.
module df_mac #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int ACC_W  = 20
) (
    input  logic     clk,
    input  logic     reset,
    df_mac_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = '1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic {IDLE, ACC} state_e;

    state_e state_q, state_d;

    logic                     v1_q;
    logic [ADDR_W-1:0]        i1_q;
    logic                     v2_q;
    logic [ADDR_W-1:0]        i2_q;
    logic signed [PROD_W-1:0] prod_q;

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     ovf_acc_q, ovf_acc_d;
    logic [ADDR_W-1:0]        exp_q, exp_d;
    logic signed [ACC_W-1:0]  sum_q, sum_d;
    logic                     ovf_q, ovf_d;
    logic                     sum_rdy_q, sum_rdy_d;
    logic                     abort_q, abort_d;

    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  add_a;
    logic signed [ACC_W:0]    add_full;
    logic                     add_ovf;
    logic signed [ACC_W-1:0]  add_sat;

    // S1 lines the address up with the RAM read; S2 holds the product.
    // NOTE: registers are written with non-blocking assignments so every stage
    // samples the previous stage's value from before this clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q   <= 1'b0;
            i1_q   <= '0;
            v2_q   <= 1'b0;
            i2_q   <= '0;
            prod_q <= '0;
        end else begin
            v1_q <= bus.sel_rdy;
            i1_q <= bus.sel;
            v2_q <= v1_q;
            i2_q <= i1_q;
            if (v1_q) begin
                prod_q <= PROD_W'(bus.x_data) * PROD_W'(bus.w_data);
            end
        end
    end

    // One shared adder: bias starts a vector in IDLE, the accumulator continues it.
    assign prod_ext = ACC_W'(prod_q);
    assign add_a    = (state_q == IDLE) ? bus.bias : acc_q;
    assign add_full = {add_a[ACC_W-1], add_a} + {prod_ext[ACC_W-1], prod_ext};
    assign add_ovf  = add_full[ACC_W] ^ add_full[ACC_W-1];
    assign add_sat  = !add_ovf ? add_full[ACC_W-1:0]
                               : (add_full[ACC_W] ? ACC_MIN : ACC_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            exp_q     <= '0;
            sum_q     <= '0;
            ovf_q     <= 1'b0;
            sum_rdy_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_acc_d;
            exp_q     <= exp_d;
            sum_q     <= sum_d;
            ovf_q     <= ovf_d;
            sum_rdy_q <= sum_rdy_d;
            abort_q   <= abort_d;
        end
    end

    // NOTE: every signal is given a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_acc_d = ovf_acc_q;
        exp_d     = exp_q;
        sum_d     = sum_q;
        ovf_d     = ovf_q;
        sum_rdy_d = 1'b0;
        abort_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Terms other than index 0 are ignored here: joining mid-vector.
                if (v2_q && (i2_q == '0)) begin
                    acc_d     = add_sat;
                    ovf_acc_d = add_ovf;
                    exp_d     = ADDR_W'(1);
                    state_d   = ACC;
                end
            end
            ACC: begin
                if (v2_q && (i2_q == exp_q)) begin
                    if (i2_q == LAST_IDX) begin
                        sum_d     = add_sat;
                        ovf_d     = ovf_acc_q | add_ovf;
                        sum_rdy_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        acc_d     = add_sat;
                        ovf_acc_d = ovf_acc_q | add_ovf;
                        exp_d     = exp_q + 1'b1;
                    end
                end else begin
                    // A gap or out-of-order term kills the vector; that term is dropped too.
                    abort_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sum     = sum_q;
    assign bus.sum_rdy = sum_rdy_q;
    assign bus.ovf     = ovf_q;
    assign bus.abort   = abort_q;
    assign bus.busy    = (state_q == ACC);
endmodule
